// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one 32-bit barrel shifter between two requesters
module shift_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_data,
   input  logic [4:0]  req0_shamt,
   input  logic [1:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_data,
   input  logic [4:0]  req1_shamt,
   input  logic [1:0]  req1_op,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [31:0] resp_result
);

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_ROTL = 2'b11;

   logic        prio;
   logic        cand;
   logic        slot_free;
   logic        accept;
   logic [31:0] sel_data;
   logic [4:0]  sel_shamt;
   logic [1:0]  sel_op;
   logic [31:0] shift_out;

   always_comb begin
      cand = 1'b0;
      if (req0_valid && req1_valid)
         cand = prio;
      else
         cand = req1_valid;
   end

   assign slot_free  = !resp_valid || resp_ready;
   // Gate with reset so neither requester sees a grant while the block is held in reset.
   assign req0_ready = !reset && slot_free && req0_valid && !cand;
   assign req1_ready = !reset && slot_free && req1_valid && cand;
   assign accept     = req0_ready || req1_ready;

   always_comb begin
      sel_data  = cand ? req1_data  : req0_data;
      sel_shamt = cand ? req1_shamt : req0_shamt;
      sel_op    = cand ? req1_op    : req0_op;
   end

   // Five log stages (1/2/4/8/16); each stage applies the op by its own power-of-two amount.
   always_comb begin
      shift_out = sel_data;
      for (int i = 0; i < 5; i++) begin
         if (sel_shamt[i]) begin
            case (sel_op)
               OP_SLL:  shift_out = shift_out << (1 << i);
               OP_SRL:  shift_out = shift_out >> (1 << i);
               OP_SRA:  shift_out = $signed(shift_out) >>> (1 << i);
               OP_ROTL: shift_out = (shift_out << (1 << i)) | (shift_out >> (32 - (1 << i)));
               default: shift_out = shift_out;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_valid  <= 1'b0;
         resp_result <= 32'd0;
         resp_id     <= 1'b0;
         prio        <= 1'b0;
      end else if (accept) begin
         resp_valid  <= 1'b1;
         resp_result <= shift_out;
         resp_id     <= cand;
         prio        <= ~cand;
      end else if (resp_ready) begin
         resp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter with a randomized reference model
module tb_shift_arbiter;

   logic        clock;
   logic        reset;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_data;
   logic [4:0]  req0_shamt;
   logic [1:0]  req0_op;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_data;
   logic [4:0]  req1_shamt;
   logic [1:0]  req1_op;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [31:0] resp_result;

   int tests_run;
   int tests_failed;

   shift_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_data   (req0_data),
      .req0_shamt  (req0_shamt),
      .req0_op     (req0_op),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_data   (req1_data),
      .req1_shamt  (req1_shamt),
      .req1_op     (req1_op),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
      case (op)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return $signed(d) >>> s;
         default: return (s == 5'd0) ? d : ((d << s) | (d >> (32 - int'(s))));
      endcase
   endfunction

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_data = 32'd0; req0_shamt = 5'd0; req0_op = 2'd0;
      req1_valid = 1'b0; req1_data = 32'd0; req1_shamt = 5'd0; req1_op = 2'd0;
      resp_ready = 1'b0;
   endtask

   // Leaves time just after a rising edge, reset released, pipeline empty.
   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
      req0_data = 32'h0000_00F0; req0_shamt = 5'd4; req0_op = 2'b01;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         tests_failed++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      tests_run++;
      if ({resp_valid, resp_id, resp_result} !== 34'd0) begin
         tests_failed++; $display("FAIL reset_outputs: got v=%b id=%b r=%h expected all zero", resp_valid, resp_id, resp_result);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++; $display("FAIL first_accept_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clock); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tests_run++;
      if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'h0000_000F}) begin
         tests_failed++; $display("FAIL first_accept_resp: got v=%b id=%b r=%h expected v=1 id=0 r=0000000f", resp_valid, resp_id, resp_result);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_single_sll();
      do_reset();
      resp_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_shamt = 5'd31; req0_op = 2'b00;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++; $display("FAIL sll_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      tests_run++;
      if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'h8000_0000}) begin
         tests_failed++; $display("FAIL sll_resp: got v=%b id=%b r=%h expected v=1 id=0 r=80000000", resp_valid, resp_id, resp_result);
      end
      @(posedge clock); #1;
      tests_run++;
      if (resp_valid !== 1'b0) begin
         tests_failed++; $display("FAIL sll_drain: got resp_valid=%b expected 0", resp_valid);
      end
   endtask

   task automatic test_ops_req1();
      logic [31:0] vd [11];
      logic [4:0]  vs [11];
      logic [1:0]  vo [11];
      logic [31:0] ve [11];
      vd[0] = 32'h8000_0010; vs[0] = 5'd4; vo[0] = 2'b10; ve[0] = 32'hF800_0001;
      vd[1] = 32'h8000_0010; vs[1] = 5'd4; vo[1] = 2'b01; ve[1] = 32'h0800_0001;
      vd[2] = 32'h8000_0001; vs[2] = 5'd1; vo[2] = 2'b11; ve[2] = 32'h0000_0003;
      for (int k = 0; k < 4; k++) begin
         vd[3+k] = 32'hA5C3_5A3C; vs[3+k] = 5'd0; vo[3+k] = 2'(k); ve[3+k] = 32'hA5C3_5A3C;
      end
      for (int k = 7; k < 11; k++) begin
         vd[k] = $urandom; vs[k] = 5'($urandom_range(1, 31)); vo[k] = 2'(k - 7);
         ve[k] = ref_shift(vd[k], vs[k], vo[k]);
      end
      do_reset();
      resp_ready = 1'b1;
      for (int k = 0; k < 11; k++) begin
         req1_valid = 1'b1; req1_data = vd[k]; req1_shamt = vs[k]; req1_op = vo[k];
         #1;
         tests_run++;
         if (req1_ready !== 1'b1) begin
            tests_failed++; $display("FAIL op_ready[%0d]: got %b expected 1", k, req1_ready);
         end
         @(posedge clock); #1;
         tests_run++;
         if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b1, ve[k]}) begin
            tests_failed++; $display("FAIL op_resp[%0d] op=%0d sh=%0d: got v=%b id=%b r=%h expected v=1 id=1 r=%h",
                                     k, vo[k], vs[k], resp_valid, resp_id, resp_result, ve[k]);
         end
      end
      req1_valid = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_contention();
      logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      resp_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 32'h0000_0003; req0_shamt = 5'd2; req0_op = 2'b00;
      req1_valid = 1'b1; req1_data = 32'h0000_0300; req1_shamt = 5'd8; req1_op = 2'b01;
      for (int k = 0; k < 4; k++) begin
         #1;
         tests_run++;
         if ({req0_ready, req1_ready} !== {~exp_g[k], exp_g[k]}) begin
            tests_failed++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, {req0_ready, req1_ready}, {~exp_g[k], exp_g[k]});
         end
         @(posedge clock); #1;
         tests_run++;
         if ({resp_valid, resp_id, resp_result} !== {1'b1, exp_g[k], exp_g[k] ? 32'h0000_0003 : 32'h0000_000C}) begin
            tests_failed++; $display("FAIL contention_resp[%0d]: got v=%b id=%b r=%h expected v=1 id=%b", k, resp_valid, resp_id, resp_result, exp_g[k]);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_backpressure();
      do_reset();
      resp_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_shamt = 5'd4; req0_op = 2'b00;
      req1_valid = 1'b1; req1_data = 32'hF000_000F; req1_shamt = 5'd4; req1_op = 2'b11;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      req0_data = 32'h0000_FFFF; req0_shamt = 5'd1; req0_op = 2'b01;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests_run++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            tests_failed++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, {req0_ready, req1_ready});
         end
         tests_run++;
         if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'h2345_6780}) begin
            tests_failed++; $display("FAIL bp_hold[%0d]: got v=%b id=%b r=%h expected v=1 id=0 r=23456780", k, resp_valid, resp_id, resp_result);
         end
         @(posedge clock); #1;
      end
      resp_ready = 1'b1;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         tests_failed++; $display("FAIL bp_release_ready: got %b expected 01", {req0_ready, req1_ready});
      end
      @(posedge clock); #1;
      req1_valid = 1'b0;
      tests_run++;
      if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b1, 32'h0000_00FF}) begin
         tests_failed++; $display("FAIL bp_release_resp: got v=%b id=%b r=%h expected v=1 id=1 r=000000ff", resp_valid, resp_id, resp_result);
      end
      req0_valid = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      resp_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 32'hDEAD_BEEF; req0_shamt = 5'd0; req0_op = 2'b00;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      req1_valid = 1'b1; req1_data = 32'h0000_0001; req1_shamt = 5'd3; req1_op = 2'b00;
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({resp_valid, resp_id, resp_result} !== 34'd0) begin
         tests_failed++; $display("FAIL midreset_outputs: got v=%b id=%b r=%h expected all zero", resp_valid, resp_id, resp_result);
      end
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         tests_failed++; $display("FAIL midreset_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      #1;
      reset = 1'b0;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++; $display("FAIL midreset_prio: got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clock); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tests_run++;
      if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
         tests_failed++; $display("FAIL midreset_resp: got v=%b id=%b r=%h expected v=1 id=0 r=deadbeef", resp_valid, resp_id, resp_result);
      end
      resp_ready = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_random();
      logic [32:0] exp_q [$];
      logic m_prio;
      logic acc0, acc1, both, cand, slot, e0, e1;
      int pushes, pops, errs_ready, errs_resp;
      m_prio = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
      pushes = 0; pops = 0; errs_ready = 0; errs_resp = 0;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_data  = $urandom; req0_shamt = 5'($urandom_range(0, 31)); req0_op = 2'($urandom_range(0, 3));
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_data  = $urandom; req1_shamt = 5'($urandom_range(0, 31)); req1_op = 2'($urandom_range(0, 3));
         end
         resp_ready = ($urandom_range(0, 2) != 0);
         #1;
         slot = (exp_q.size() == 0) || resp_ready;
         both = req0_valid && req1_valid;
         cand = both ? m_prio : req1_valid;
         e0 = slot && req0_valid && (cand == 1'b0);
         e1 = slot && req1_valid && (cand == 1'b1);
         tests_run++;
         if ({req0_ready, req1_ready} !== {e0, e1}) begin
            tests_failed++; errs_ready++;
            if (errs_ready < 5) $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, {req0_ready, req1_ready}, {e0, e1});
         end
         tests_run++;
         if (resp_valid !== (exp_q.size() != 0) ||
             (exp_q.size() != 0 && {resp_id, resp_result} !== exp_q[0])) begin
            tests_failed++; errs_resp++;
            if (errs_resp < 5) $display("FAIL rand_resp cyc %0d: got v=%b id=%b r=%h expected v=%0d front=%h",
                                        cyc, resp_valid, resp_id, resp_result, exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : 33'd0);
         end
         @(posedge clock);
         if (exp_q.size() != 0 && resp_ready) begin
            void'(exp_q.pop_front());
            pops++;
         end
         if (e0 || e1) begin
            exp_q.push_back(e1 ? {1'b1, ref_shift(req1_data, req1_shamt, req1_op)}
                               : {1'b0, ref_shift(req0_data, req0_shamt, req0_op)});
            pushes++;
            m_prio = ~e1;
         end
         acc0 = e0; acc1 = e1;
         #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         tests_run++;
         if (resp_valid !== 1'b1 || {resp_id, resp_result} !== exp_q[0]) begin
            tests_failed++; $display("FAIL rand_drain: got v=%b id=%b r=%h expected v=1 front=%h", resp_valid, resp_id, resp_result, exp_q[0]);
         end
         @(posedge clock); #1;
         void'(exp_q.pop_front());
         pops++;
      end
      tests_run++;
      if (resp_valid !== 1'b0 || pushes != pops || pushes < 100) begin
         tests_failed++; $display("FAIL rand_count: got resp_valid=%b pushes=%0d pops=%0d expected 0 and equal counts", resp_valid, pushes, pops);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      idle_inputs();
      reset = 1'b1;
      @(posedge clock); #1;
      test_reset();
      test_single_sll();
      test_ops_req1();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
